// File: rtl/mips32_pkg.sv
// rtl/mips32_pkg.sv - shared MIPS32 core types and constants used by the memory arbiter
package mips32_pkg;

  localparam int MIPS32_ADDR_W = 10;
  localparam int MIPS32_DATA_W = 32;

  localparam logic [5:0] MIPS32_OP_HLT = 6'h3f;

  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_IF_RD = 2'd1,
    OWN_DM_RD = 2'd2
  } owner_e;

endpackage

// File: rtl/mips32_starve_ctr.sv
// rtl/mips32_starve_ctr.sv - saturating count of consecutive lost IF arbitrations, with force flag
module mips32_starve_ctr #(
  parameter int LIMIT = 3,
  parameter int CNT_W = 4
) (
  input  logic clk1,
  input  logic rst_n,
  input  logic i_lose,
  output logic o_force
);

  localparam logic [CNT_W-1:0] LIM = CNT_W'(LIMIT);

  logic [CNT_W-1:0] r_cnt;

  // Any cycle IF does not lose (granted or not requesting) restarts the wait.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (!i_lose) begin
      r_cnt <= '0;
    end else if (r_cnt != LIM) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_force = (r_cnt == LIM);

endmodule

// File: rtl/mips32_mem_arbiter.sv
// rtl/mips32_mem_arbiter.sv - IF/DM single-port memory arbiter, DM priority with IF starvation guard (opt. MIPS32_ARB_STATS_EN)
module mips32_mem_arbiter
  import mips32_pkg::*;
#(
  parameter int ADDR_W       = MIPS32_ADDR_W,
  parameter int DATA_W       = MIPS32_DATA_W,
  parameter int STARVE_LIMIT = 3
) (
  input  logic              clk1,
  input  logic              rst_n,
  input  logic              halted,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef MIPS32_ARB_STATS_EN
  ,
  output logic [15:0]       stat_if_grants,
  output logic [15:0]       stat_dm_grants,
  output logic [15:0]       stat_conflicts,
  output logic [15:0]       stat_forced
`endif
);

  logic              w_ifv;
  logic              w_force_if;
  logic              w_lose;
  owner_e            r_owner;
  owner_e            w_owner_nxt;
  logic [DATA_W-1:0] r_if_rdata;
  logic [DATA_W-1:0] r_dm_rdata;

  assign w_ifv  = if_req & ~halted;
  assign w_lose = w_ifv & ~if_gnt;

  mips32_starve_ctr #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clk1    (clk1),
    .rst_n   (rst_n),
    .i_lose  (w_lose),
    .o_force (w_force_if)
  );

  always_comb begin
    if_gnt    = w_ifv & (~dm_req | w_force_if);
    dm_gnt    = dm_req & ~if_gnt;
    mem_en    = if_gnt | dm_gnt;
    mem_we    = dm_gnt & dm_we;
    mem_addr  = if_gnt ? if_addr : dm_addr;
    mem_wdata = if_gnt ? '0 : dm_wdata;
  end

  // Stores complete at grant, so only reads claim the response slot.
  always_comb begin
    w_owner_nxt = OWN_NONE;
    if (if_gnt) begin
      w_owner_nxt = OWN_IF_RD;
    end else if (dm_gnt && !dm_we) begin
      w_owner_nxt = OWN_DM_RD;
    end
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      r_owner    <= OWN_NONE;
      r_if_rdata <= '0;
      r_dm_rdata <= '0;
    end else begin
      r_owner <= w_owner_nxt;
      if (r_owner == OWN_IF_RD) begin
        r_if_rdata <= mem_rdata;
      end
      if (r_owner == OWN_DM_RD) begin
        r_dm_rdata <= mem_rdata;
      end
    end
  end

  // Memory data arrives in the rvalid cycle; the register keeps it afterwards.
  assign if_rvalid = (r_owner == OWN_IF_RD);
  assign dm_rvalid = (r_owner == OWN_DM_RD);
  assign if_rdata  = if_rvalid ? mem_rdata : r_if_rdata;
  assign dm_rdata  = dm_rvalid ? mem_rdata : r_dm_rdata;

`ifdef MIPS32_ARB_STATS_EN
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      stat_if_grants <= '0;
      stat_dm_grants <= '0;
      stat_conflicts <= '0;
      stat_forced    <= '0;
    end else begin
      if (if_gnt && stat_if_grants != 16'hffff) begin
        stat_if_grants <= stat_if_grants + 16'd1;
      end
      if (dm_gnt && stat_dm_grants != 16'hffff) begin
        stat_dm_grants <= stat_dm_grants + 16'd1;
      end
      if (w_ifv && dm_req && stat_conflicts != 16'hffff) begin
        stat_conflicts <= stat_conflicts + 16'd1;
      end
      if (w_force_if && dm_req && if_gnt && stat_forced != 16'hffff) begin
        stat_forced <= stat_forced + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mips32_mem_arbiter.sv
// tb/tb_mips32_mem_arbiter.sv - scoreboard bench for mips32_mem_arbiter with random and directed traffic
module tb_mips32_mem_arbiter;

  localparam int AW  = 10;
  localparam int DW  = 32;
  localparam int LIM = 3;

  typedef struct {
    int            cyc;
    logic [DW-1:0] data;
  } resp_t;

  logic          clk1 = 1'b0;
  logic          rst_n;
  logic          halted;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_rvalid;
  logic [DW-1:0] if_rdata;
  logic          dm_req;
  logic          dm_we;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic          dm_gnt;
  logic          dm_rvalid;
  logic [DW-1:0] dm_rdata;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
`ifdef MIPS32_ARB_STATS_EN
  logic [15:0]   stat_if_grants;
  logic [15:0]   stat_dm_grants;
  logic [15:0]   stat_conflicts;
  logic [15:0]   stat_forced;
`endif

  mips32_mem_arbiter #(
    .ADDR_W       (AW),
    .DATA_W       (DW),
    .STARVE_LIMIT (LIM)
  ) dut (
    .clk1      (clk1),
    .rst_n     (rst_n),
    .halted    (halted),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_gnt    (if_gnt),
    .if_rvalid (if_rvalid),
    .if_rdata  (if_rdata),
    .dm_req    (dm_req),
    .dm_we     (dm_we),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_gnt    (dm_gnt),
    .dm_rvalid (dm_rvalid),
    .dm_rdata  (dm_rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
`ifdef MIPS32_ARB_STATS_EN
    ,
    .stat_if_grants (stat_if_grants),
    .stat_dm_grants (stat_dm_grants),
    .stat_conflicts (stat_conflicts),
    .stat_forced    (stat_forced)
`endif
  );

  always #5 clk1 = ~clk1;

  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    if (a == 10'd0)   return 32'h28010078;
    if (a == 10'd120) return 32'd85;
    return (32'(a) * 32'h9e3779b1) ^ 32'h5a5a0000;
  endfunction

  // Memory array behind the arbiter: one-cycle read latency.
  logic [DW-1:0] env_mem [0:1023];
  bit            env_wr  [0:1023];
  always @(posedge clk1) begin
    if (mem_en && mem_we) begin
      env_mem[mem_addr] <= mem_wdata;
      env_wr[mem_addr]  <= 1'b1;
    end
    if (mem_en && !mem_we) begin
      mem_rdata <= env_wr[mem_addr] ? env_mem[mem_addr] : init_val(mem_addr);
    end
  end

  int            total = 0;
  int            bad = 0;
  int            cyc = 0;
  int            losses = 0;
  bit            exp_if_g;
  bit            exp_dm_g;
  bit            s_if_gnt;
  logic [DW-1:0] ref_mem [0:1023];
  bit            ref_wr  [0:1023];
  resp_t         if_q[$];
  resp_t         dm_q[$];

  function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
    return ref_wr[a] ? ref_mem[a] : init_val(a);
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // Reference: DM wins unless IF has already lost LIM cycles in a row.
  task automatic cycle();
    bit    ifv;
    resp_t r;
    @(negedge clk1);
    ifv      = if_req && !halted;
    exp_if_g = ifv && (!dm_req || losses == LIM);
    exp_dm_g = dm_req && !exp_if_g;
    s_if_gnt = if_gnt;
    chk("if_gnt", 32'(if_gnt), 32'(exp_if_g));
    chk("dm_gnt", 32'(dm_gnt), 32'(exp_dm_g));
    chk("mem_en", 32'(mem_en), 32'(exp_if_g || exp_dm_g));
    chk("mem_we", 32'(mem_we), 32'(exp_dm_g && dm_we));
    r.cyc = cyc;
    if (exp_if_g) begin
      chk("mem_addr_if", 32'(mem_addr), 32'(if_addr));
      chk("mem_wdata_if", mem_wdata, 32'd0);
      r.data = ref_rd(if_addr);
      if_q.push_back(r);
    end else if (exp_dm_g) begin
      chk("mem_addr_dm", 32'(mem_addr), 32'(dm_addr));
      if (dm_we) begin
        chk("mem_wdata_dm", mem_wdata, dm_wdata);
        ref_mem[dm_addr] = dm_wdata;
        ref_wr[dm_addr]  = 1'b1;
      end else begin
        r.data = ref_rd(dm_addr);
        dm_q.push_back(r);
      end
    end
    if (ifv && !exp_if_g) losses = (losses < LIM) ? losses + 1 : LIM;
    else                  losses = 0;
    @(posedge clk1);
    #1;
    cyc++;
  endtask

  task automatic monitor();
    bit    ev;
    resp_t r;
    forever begin
      @(negedge clk1);
      #2;
      ev = (if_q.size() > 0) && (if_q[0].cyc < cyc);
      chk("if_rvalid", 32'(if_rvalid), 32'(ev));
      if (ev) begin
        r = if_q.pop_front();
        if (if_rvalid) chk("if_rdata", if_rdata, r.data);
      end
      ev = (dm_q.size() > 0) && (dm_q[0].cyc < cyc);
      chk("dm_rvalid", 32'(dm_rvalid), 32'(ev));
      if (ev) begin
        r = dm_q.pop_front();
        if (dm_rvalid) chk("dm_rdata", dm_rdata, r.data);
      end
    end
  endtask

  task automatic drive(input bit ir, input int ia, input bit dr, input bit dw,
                       input int da, input logic [DW-1:0] dd, input bit h);
    if_req   = ir;
    if_addr  = AW'(ia);
    dm_req   = dr;
    dm_we    = dw;
    dm_addr  = AW'(da);
    dm_wdata = dd;
    halted   = h;
  endtask

  initial begin
    bit pat [8];
    pat = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    rst_n = 1'b0;
    drive(1'b0, 0, 1'b0, 1'b0, 0, '0, 1'b0);
    fork
      monitor();
    join_none

    #2;
    chk("rst_if_rvalid", 32'(if_rvalid), 32'd0);
    chk("rst_dm_rvalid", 32'(dm_rvalid), 32'd0);
    chk("rst_if_rdata", if_rdata, 32'd0);
    chk("rst_dm_rdata", dm_rdata, 32'd0);
    if_req = 1'b1;
    #1;
    chk("rst_comb_if_gnt", 32'(if_gnt), 32'd1);
    if_req = 1'b0;
    @(posedge clk1);
    @(posedge clk1);
    #1;
    rst_n = 1'b1;

    drive(1'b1, 0, 1'b0, 1'b0, 0, '0, 1'b0);
    cycle();
    drive(1'b0, 0, 1'b0, 1'b0, 0, '0, 1'b0);
    chk("fetch0_data", if_rdata, 32'h28010078);
    cycle();

    drive(1'b1, 4, 1'b1, 1'b0, 120, '0, 1'b0);
    cycle();
    chk("conflict_dm_wins", 32'(s_if_gnt), 32'd0);
    dm_req = 1'b0;
    cycle();
    chk("conflict_if_next", 32'(s_if_gnt), 32'd1);
    chk("load120_data", dm_rdata, 32'd85);
    drive(1'b0, 0, 1'b1, 1'b1, 121, 32'd130, 1'b0);
    cycle();
    dm_we = 1'b0;
    cycle();
    drive(1'b0, 0, 1'b0, 1'b0, 0, '0, 1'b0);
    chk("load121_data", dm_rdata, 32'd130);
    cycle();

    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 8, i[0], 1'b0, 120 + i, '0, 1'b1);
      cycle();
      chk("halted_no_if_gnt", 32'(s_if_gnt), 32'd0);
    end
    drive(1'b1, 9, 1'b0, 1'b0, 0, '0, 1'b0);
    cycle();
    halted = 1'b1;
    cycle();
    chk("halt_inflight_no_gnt", 32'(s_if_gnt), 32'd0);

    drive(1'b1, 12, 1'b1, 1'b0, 33, '0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      cycle();
      chk($sformatf("starve_pat%0d", i), 32'(s_if_gnt), 32'(pat[i]));
    end
    drive(1'b0, 0, 1'b0, 1'b0, 0, '0, 1'b0);
    cycle();

    for (int n = 0; n < 400; n++) begin
      if (!if_req || exp_if_g) begin
        if_req  = ($urandom_range(0, 3) != 0);
        if_addr = AW'($urandom_range(0, 31));
      end
      if (!dm_req || exp_dm_g) begin
        dm_req   = ($urandom_range(0, 1) != 0);
        dm_we    = ($urandom_range(0, 2) == 0);
        dm_addr  = AW'($urandom_range(0, 31));
        dm_wdata = $urandom;
      end
      halted = ($urandom_range(0, 11) == 0);
      cycle();
    end
    drive(1'b0, 0, 1'b0, 1'b0, 0, '0, 1'b0);
    cycle();
    cycle();
    chk("if_q_drained", 32'(if_q.size()), 32'd0);
    chk("dm_q_drained", 32'(dm_q.size()), 32'd0);

    drive(1'b0, 0, 1'b1, 1'b0, 120, '0, 1'b0);
    cycle();
    drive(1'b1, 0, 1'b0, 1'b0, 0, '0, 1'b0);
    cycle();
    drive(1'b0, 0, 1'b0, 1'b0, 0, '0, 1'b0);
    rst_n = 1'b0;
    if_q.delete();
    dm_q.delete();
    losses = 0;
    #1;
    chk("midrst_if_rvalid", 32'(if_rvalid), 32'd0);
    chk("midrst_if_rdata", if_rdata, 32'd0);
    chk("midrst_dm_rdata", dm_rdata, 32'd0);
    cycle();
    #2;
    rst_n = 1'b1;
    cycle();
    cycle();
    chk("postrst_if_rdata", if_rdata, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
